// File: rtl/eth_fcs_pkg.sv
// Shared constants and FSM state type for the Ethernet FCS engine.
package eth_fcs_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_DATA,
    ST_FCS,
    ST_DRAIN
  } fcs_state_e;

endpackage

// File: rtl/crc32_bytes.sv
// Combinational reflected CRC-32 update over the first nbytes bytes of an NB-byte word.
module crc32_bytes
  import eth_fcs_pkg::*;
#(
  parameter int NB = 1
)(
  input  logic [31:0]              crc_in,
  input  logic [8*NB-1:0]          data,
  input  logic [$clog2(NB+1)-1:0]  nbytes,
  output logic [31:0]              crc_out
);

  localparam int CNT_W = $clog2(NB + 1);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < NB; b++) begin
      if (CNT_W'(b) < nbytes) c = crc32_byte(c, data[8*b +: 8]);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_fcs_engine.sv
// Ethernet FCS engine: passes frames through and appends the CRC-32 FCS.
// Define ETH_FCS_CHECK_EN to add cfg_append and a received-FCS residue check (chk_valid/chk_ok).
module eth_fcs_engine
  import eth_fcs_pkg::*;
#(
  parameter int DATA_W = 8
)(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [DATA_W/8-1:0]   s_keep,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic [DATA_W/8-1:0]   m_keep,
  output logic                  m_last
`ifdef ETH_FCS_CHECK_EN
  ,
  input  logic                  cfg_append,
  output logic                  chk_valid,
  output logic                  chk_ok
`endif
);

  localparam int         NB        = DATA_W / 8;
  localparam int         CNT_W     = $clog2(NB + 1);
  localparam int         FCS_BEATS = (4 + NB - 1) / NB;
  localparam logic [1:0] FCS_LAST  = 2'(FCS_BEATS - 1);

  fcs_state_e       state_q, state_d;
  logic [31:0]      crc_q, crc_next, fcs_q;
  logic [1:0]       fcs_cnt_q;
  logic [CNT_W-1:0] nbytes;
  logic             out_free, accept, append_eff, fcs_emit, fcs_final;

`ifdef ETH_FCS_CHECK_EN
  logic in_frame_q, append_q;
  // cfg_append is only honoured on a frame's first beat; later beats use the latched copy
  assign append_eff = in_frame_q ? append_q : cfg_append;
`else
  assign append_eff = 1'b1;
`endif

  assign out_free  = !m_valid || m_ready;
  assign accept    = s_valid && s_ready;
  assign fcs_emit  = (state_q == ST_FCS) && out_free;
  assign fcs_final = fcs_emit && (fcs_cnt_q == FCS_LAST);

  always_comb begin
    nbytes = '0;
    for (int i = 0; i < NB; i++) nbytes = nbytes + CNT_W'(s_keep[i]);
  end

  crc32_bytes #(.NB(NB)) u_crc (
    .crc_in  (crc_q),
    .data    (s_data),
    .nbytes  (nbytes),
    .crc_out (crc_next)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_DATA;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    case (state_q)
      ST_DATA: begin
        s_ready = out_free && !Reset;
        if (s_valid && s_ready && s_last) state_d = append_eff ? ST_FCS : ST_DRAIN;
      end
      ST_FCS:   if (fcs_final) state_d = ST_DATA;
      ST_DRAIN: if (m_valid && m_ready) state_d = ST_DATA;
      default:  state_d = ST_DATA;
    endcase
  end

  // Output register stage: data beats, then FCS beats unpacked low byte first
  always_ff @(posedge Clk) begin
    if (Reset) begin
      crc_q     <= CRC32_INIT;
      fcs_cnt_q <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_last    <= 1'b0;
    end else if (accept) begin
      crc_q   <= s_last ? CRC32_INIT : crc_next;
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_keep  <= s_keep;
      m_last  <= s_last && !append_eff;
    end else if (fcs_emit) begin
      m_valid   <= 1'b1;
      m_data    <= fcs_q[DATA_W*int'(fcs_cnt_q) +: DATA_W];
      m_keep    <= '1;
      m_last    <= fcs_final;
      fcs_cnt_q <= fcs_final ? 2'd0 : fcs_cnt_q + 2'd1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept && s_last) fcs_q <= ~crc_next;
  end

`ifdef ETH_FCS_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_frame_q <= 1'b0;
      append_q   <= 1'b1;
      chk_valid  <= 1'b0;
      chk_ok     <= 1'b0;
    end else begin
      chk_valid <= accept && s_last && !append_eff;
      if (accept) begin
        in_frame_q <= !s_last;
        if (!in_frame_q) append_q <= cfg_append;
        if (s_last && !append_eff) chk_ok <= (crc_next == CRC32_RESIDUE);
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_fcs_engine.sv
// Directed bench for eth_fcs_engine at 8/16/32-bit widths with a byte-level scoreboard.
module tb_eth_fcs_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   ncomp = 0, nfail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        s_valid8, s_ready8, s_last8, m_valid8, m_ready8, m_last8;
  logic [7:0]  s_data8, m_data8;
  logic [0:0]  s_keep8, m_keep8;
  logic        s_valid16, s_ready16, s_last16, m_valid16, m_ready16, m_last16;
  logic [15:0] s_data16, m_data16;
  logic [1:0]  s_keep16, m_keep16;
  logic        s_valid32, s_ready32, s_last32, m_valid32, m_ready32, m_last32;
  logic [31:0] s_data32, m_data32;
  logic [3:0]  s_keep32, m_keep32;
`ifdef ETH_FCS_CHECK_EN
  logic cfg8, cfg16, cfg32, cv8, co8, cv16, co16, cv32, co32;
`endif

  eth_fcs_engine #(.DATA_W(8)) u8 (
    .Clk(clk), .Reset(rst), .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
    .s_keep(s_keep8), .s_last(s_last8), .m_valid(m_valid8), .m_ready(m_ready8),
    .m_data(m_data8), .m_keep(m_keep8), .m_last(m_last8)
`ifdef ETH_FCS_CHECK_EN
    , .cfg_append(cfg8), .chk_valid(cv8), .chk_ok(co8)
`endif
  );
  eth_fcs_engine #(.DATA_W(16)) u16 (
    .Clk(clk), .Reset(rst), .s_valid(s_valid16), .s_ready(s_ready16), .s_data(s_data16),
    .s_keep(s_keep16), .s_last(s_last16), .m_valid(m_valid16), .m_ready(m_ready16),
    .m_data(m_data16), .m_keep(m_keep16), .m_last(m_last16)
`ifdef ETH_FCS_CHECK_EN
    , .cfg_append(cfg16), .chk_valid(cv16), .chk_ok(co16)
`endif
  );
  eth_fcs_engine #(.DATA_W(32)) u32 (
    .Clk(clk), .Reset(rst), .s_valid(s_valid32), .s_ready(s_ready32), .s_data(s_data32),
    .s_keep(s_keep32), .s_last(s_last32), .m_valid(m_valid32), .m_ready(m_ready32),
    .m_data(m_data32), .m_keep(m_keep32), .m_last(m_last32)
`ifdef ETH_FCS_CHECK_EN
    , .cfg_append(cfg32), .chk_valid(cv32), .chk_ok(co32)
`endif
  );

  logic [8:0] expq [3][$];
  logic [7:0] frame_q [$];
  logic       ign [3];
  int         lastq2 [$];
  int         first_acc_cyc;
  logic       rnd16 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fcs_model();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frame_q[i]) begin
      c = c ^ {24'h0, frame_q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Each kept output byte is popped from the expected queue as {is_last_byte, byte}
  task automatic mon(input int sel, input logic v, input logic r, input logic [31:0] d,
                     input logic [3:0] k, input logic l);
    int nb;
    int top;
    logic [8:0] obs;
    nb  = 1 << sel;
    top = -1;
    if (!(v && r) || ign[sel]) return;
    for (int i = 0; i < nb; i++) if (k[i]) top = i;
    if (l && sel == 2) lastq2.push_back(cyc);
    for (int i = 0; i < nb; i++) begin
      if (k[i]) begin
        obs = {l && (i == top), d[8*i +: 8]};
        if (expq[sel].size() == 0) chk($sformatf("sb%0d_extra_byte_%0h", sel, obs), 64'(expq[sel].size()), 64'd1);
        else chk($sformatf("sb%0d_byte", sel), 64'(obs), 64'(expq[sel].pop_front()));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, m_valid8,  m_ready8,  32'(m_data8),  4'(m_keep8),  m_last8);
    mon(1, m_valid16, m_ready16, 32'(m_data16), 4'(m_keep16), m_last16);
    mon(2, m_valid32, m_ready32, m_data32,      m_keep32,     m_last32);
  end

  logic        stall16 = 1'b0;
  logic [19:0] hold16_v;
  always @(negedge clk) begin
    if (stall16) chk("hold16", 64'({m_valid16, m_data16, m_keep16, m_last16}), 64'(hold16_v));
    stall16  = m_valid16 && !m_ready16;
    hold16_v = {m_valid16, m_data16, m_keep16, m_last16};
  end

`ifdef ETH_FCS_CHECK_EN
  int   cpulse = 0;
  logic cok = 1'b0;
  always @(negedge clk) if (cv8) begin cpulse++; cok = co8; end
`endif

  initial begin
    forever begin
      @(posedge clk); #1;
      m_ready16 = rnd16 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive(input int sel, input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
    case (sel)
      0:       begin s_valid8  = v; s_data8  = d[7:0];  s_keep8  = k[0:0]; s_last8  = l; end
      1:       begin s_valid16 = v; s_data16 = d[15:0]; s_keep16 = k[1:0]; s_last16 = l; end
      default: begin s_valid32 = v; s_data32 = d;       s_keep32 = k;      s_last32 = l; end
    endcase
  endtask

  function automatic logic get_rdy(input int sel);
    case (sel)
      0:       return s_ready8;
      1:       return s_ready16;
      default: return s_ready32;
    endcase
  endfunction

  task automatic wait_accept(input int sel, input logic first);
    int t;
    logic r;
    t = 0;
    forever begin
      @(negedge clk);
      r = get_rdy(sel);
      if (r && first) first_acc_cyc = cyc;
      @(posedge clk); #1;
      if (r) break;
      t++;
      if (t > 500) begin
        chk($sformatf("accept_timeout%0d", sel), 64'(t), 64'd0);
        break;
      end
    end
  endtask

  task automatic send_frame(input int sel, input logic hold, input logic zlast);
    int nb, n, beats, idx;
    logic [31:0] d;
    logic [3:0]  k;
    nb = 1 << sel;
    n  = frame_q.size();
    beats = (n == 0) ? 1 : (n + nb - 1) / nb + (zlast ? 1 : 0);
    for (int b = 0; b < beats; b++) begin
      d = '0;
      k = '0;
      for (int i = 0; i < nb; i++) begin
        idx = b * nb + i;
        if (idx < n) begin d[8*i +: 8] = frame_q[idx]; k[i] = 1'b1; end
      end
      drive(sel, 1'b1, d, k, b == beats - 1);
      wait_accept(sel, b == 0);
    end
    if (!hold) drive(sel, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic push_exp(input int sel, input logic app, input logic [31:0] fcs);
    int n;
    n = frame_q.size();
    for (int i = 0; i < n; i++) expq[sel].push_back({!app && (i == n - 1), frame_q[i]});
    if (app) for (int j = 0; j < 4; j++) expq[sel].push_back({j == 3, fcs[8*j +: 8]});
  endtask

  task automatic load_std();
    frame_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  task automatic load_rand(input int n);
    frame_q.delete();
    repeat (n) frame_q.push_back(8'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin ign[s] = 1'b0; drive(s, 1'b0, '0, '0, 1'b0); end
    m_ready8 = 1'b1; m_ready32 = 1'b1;
`ifdef ETH_FCS_CHECK_EN
    cfg8 = 1'b1; cfg16 = 1'b1; cfg32 = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready8", 64'(s_ready8), 64'd0);
    chk("rst_s_ready16", 64'(s_ready16), 64'd0);
    chk("rst_m_valid8", 64'(m_valid8), 64'd0);
    chk("rst_m_valid32", 64'(m_valid32), 64'd0);
    chk("rst_m_data32", 64'(m_data32), 64'd0);
    chk("rst_m_keep32", 64'(m_keep32), 64'd0);
    chk("rst_m_last8", 64'(m_last8), 64'd0);
    chk("rst_m_data16", 64'(m_data16), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready8", 64'(s_ready8), 64'd1);
    chk("post_rst_s_ready16", 64'(s_ready16), 64'd1);
    chk("post_rst_s_ready32", 64'(s_ready32), 64'd1);
    @(posedge clk); #1;

    // 8-bit and 32-bit "123456789" against the known check value
    load_std(); push_exp(0, 1'b1, 32'hCBF43926); send_frame(0, 1'b0, 1'b0);
    load_std(); push_exp(2, 1'b1, 32'hCBF43926); send_frame(2, 1'b0, 1'b0);
    idle(10);

    // 16-bit under random backpressure, including an empty last beat
    rnd16 = 1'b1;
    load_std(); push_exp(1, 1'b1, 32'hCBF43926); send_frame(1, 1'b0, 1'b0);
    load_rand(14); push_exp(1, 1'b1, fcs_model()); send_frame(1, 1'b0, 1'b1);
    idle(60);
    rnd16 = 1'b0;
    idle(5);

    // zero-length frames
    frame_q.delete(); push_exp(2, 1'b1, 32'h0); send_frame(2, 1'b0, 1'b0);
    frame_q.delete(); push_exp(0, 1'b1, 32'h0); send_frame(0, 1'b0, 1'b0);
    load_rand(11); push_exp(2, 1'b1, fcs_model()); send_frame(2, 1'b0, 1'b0);
    idle(10);

    // back-to-back frames with s_valid held high
    lastq2.delete();
    load_std(); push_exp(2, 1'b1, 32'hCBF43926); send_frame(2, 1'b1, 1'b0);
    load_rand(7); push_exp(2, 1'b1, fcs_model()); send_frame(2, 1'b0, 1'b0);
    idle(10);
    chk("b2b_fcs_count", 64'(lastq2.size()), 64'd2);
    if (lastq2.size() > 0) chk("b2b_same_cycle", 64'(first_acc_cyc), 64'(lastq2[0]));

    // reset in the middle of a frame
    ign[0] = 1'b1;
    load_std();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 32'(frame_q[i]), 4'h1, 1'b0);
      wait_accept(0, 1'b0);
    end
    drive(0, 1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_rst_m_valid8", 64'(m_valid8), 64'd0);
    chk("abort_rst_s_ready8", 64'(s_ready8), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_post_s_ready8", 64'(s_ready8), 64'd1);
    ign[0] = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); seen += int'(m_valid8); end
    chk("abort_no_fcs", 64'(seen), 64'd0);
    @(posedge clk); #1;
    load_std(); push_exp(0, 1'b1, 32'hCBF43926); send_frame(0, 1'b0, 1'b0);
    idle(12);

`ifdef ETH_FCS_CHECK_EN
    cfg8 = 1'b0;
    load_std();
    frame_q.push_back(8'h26); frame_q.push_back(8'h39); frame_q.push_back(8'hF4); frame_q.push_back(8'hCB);
    cpulse = 0;
    push_exp(0, 1'b0, 32'h0); send_frame(0, 1'b0, 1'b0);
    idle(6);
    chk("chk_good_pulses", 64'(cpulse), 64'd1);
    chk("chk_good_ok", 64'(cok), 64'd1);
    frame_q[4] = frame_q[4] ^ 8'h01;
    cpulse = 0;
    push_exp(0, 1'b0, 32'h0); send_frame(0, 1'b0, 1'b0);
    idle(6);
    chk("chk_bad_pulses", 64'(cpulse), 64'd1);
    chk("chk_bad_ok", 64'(cok), 64'd0);
    cfg8 = 1'b1;
`endif

    idle(20);
    for (int s = 0; s < 3; s++) chk($sformatf("sb%0d_leftover", s), 64'(expq[s].size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
